// File: rtl/flappy_game_ctrl.sv
// Flappy game sequencer: Initial/Play/Lose FSM, per-frame pipe collision scan,
// movement tick generation and saturating two-digit BCD score.
module flappy_game_ctrl #(
   parameter int unsigned TICK_DIV = 2,
   parameter int unsigned FLOOR_Y  = 470,
   parameter int unsigned CEIL_Y   = 0
) (
   input  logic       board_clk,
   input  logic       Reset,
   input  logic       start_pulse,
   input  logic       ack_pulse,
   input  logic       jump_pulse,
   input  logic       frame_start,
   input  logic       pipe_passed,
   input  logic [9:0] bird_l,
   input  logic [9:0] bird_r,
   input  logic [9:0] bird_t,
   input  logic [9:0] bird_b,
   output logic [1:0] pipe_idx,
   input  logic [9:0] pipe_x_l,
   input  logic [9:0] pipe_x_r,
   input  logic [9:0] gap_t,
   input  logic [9:0] gap_b,
   output logic       move_en,
   output logic       jump_req,
   output logic       q_initial,
   output logic       q_play,
   output logic       q_lose,
   output logic [7:0] score,
   output logic [1:0] hit_pipe
);
   typedef enum logic [2:0] {S_INITIAL, S_WAIT, S_SCAN, S_UPDATE, S_LOSE} state_t;

   localparam logic [9:0] FLOOR_V   = 10'(FLOOR_Y);
   localparam logic [9:0] CEIL_V    = 10'(CEIL_Y);
   localparam logic [3:0] TICK_LAST = 4'(TICK_DIV - 1);

   state_t     state_q;
   logic [2:0] scan_cyc_q;
   logic [3:0] frame_cnt_q;
   logic       jump_pend_q;
   logic       hit_q;
   logic [1:0] pipe_idx_q;
   logic       move_en_q, jump_req_q;
   logic       q_initial_q, q_play_q, q_lose_q;
   logic [7:0] score_q;
   logic [1:0] hit_pipe_q;

   logic       pipe_hit_d, bound_hit_d;
   logic [2:0] scan_nxt_d;
   logic [7:0] score_inc_d;

   assign pipe_hit_d  = (bird_r >= pipe_x_l) && (bird_l <= pipe_x_r) &&
                        ((bird_t <= gap_t) || (bird_b >= gap_b));
   assign bound_hit_d = (bird_b >= FLOOR_V) || (bird_t <= CEIL_V);
   // wraps to 0 after cycle 7, which parks pipe_idx at 0 for the next frame
   assign scan_nxt_d  = scan_cyc_q + 3'd1;
   assign score_inc_d = (score_q[3:0] == 4'd9) ? {score_q[7:4] + 4'd1, 4'd0}
                                               : {score_q[7:4], score_q[3:0] + 4'd1};

   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= S_INITIAL;
         scan_cyc_q  <= '0;
         frame_cnt_q <= '0;
         jump_pend_q <= 1'b0;
         hit_q       <= 1'b0;
         pipe_idx_q  <= '0;
         move_en_q   <= 1'b0;
         jump_req_q  <= 1'b0;
         q_initial_q <= 1'b1;
         q_play_q    <= 1'b0;
         q_lose_q    <= 1'b0;
         score_q     <= '0;
         hit_pipe_q  <= '0;
      end else begin
         move_en_q  <= 1'b0;
         jump_req_q <= 1'b0;
         if (pipe_passed && q_play_q && score_q != 8'h99) score_q <= score_inc_d;
         if (jump_pulse && q_play_q) jump_pend_q <= 1'b1;
         case (state_q)
            S_INITIAL: if (start_pulse) begin
               state_q     <= S_WAIT;
               q_initial_q <= 1'b0;
               q_play_q    <= 1'b1;
               score_q     <= '0;
               frame_cnt_q <= '0;
               jump_pend_q <= 1'b0;
               hit_q       <= 1'b0;
               hit_pipe_q  <= '0;
            end
            S_WAIT: if (frame_start) begin
               state_q    <= S_SCAN;
               scan_cyc_q <= '0;
               pipe_idx_q <= '0;
            end
            S_SCAN: begin
               // odd cycles see geometry for the pipe selected on the even cycle
               if (scan_cyc_q[0] && pipe_hit_d && !hit_q) begin
                  hit_q      <= 1'b1;
                  hit_pipe_q <= scan_cyc_q[2:1];
               end
               scan_cyc_q <= scan_nxt_d;
               pipe_idx_q <= scan_nxt_d[2:1];
               if (scan_cyc_q == 3'd7) state_q <= S_UPDATE;
            end
            S_UPDATE: if (hit_q || bound_hit_d) begin
               state_q     <= S_LOSE;
               q_play_q    <= 1'b0;
               q_lose_q    <= 1'b1;
               jump_pend_q <= 1'b0;
            end else begin
               state_q <= S_WAIT;
               if (frame_cnt_q == TICK_LAST) begin
                  move_en_q   <= 1'b1;
                  jump_req_q  <= jump_pend_q;
                  jump_pend_q <= jump_pulse;
                  frame_cnt_q <= '0;
               end else begin
                  frame_cnt_q <= frame_cnt_q + 4'd1;
               end
            end
            S_LOSE: if (ack_pulse) begin
               state_q     <= S_INITIAL;
               q_lose_q    <= 1'b0;
               q_initial_q <= 1'b1;
               jump_pend_q <= 1'b0;
            end
            default: state_q <= S_INITIAL;
         endcase
      end
   end

   assign pipe_idx  = pipe_idx_q;
   assign move_en   = move_en_q;
   assign jump_req  = jump_req_q;
   assign q_initial = q_initial_q;
   assign q_play    = q_play_q;
   assign q_lose    = q_lose_q;
   assign score     = score_q;
   assign hit_pipe  = hit_pipe_q;
endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed bench for flappy_game_ctrl: ticks, jumps, collisions, score, reset.
module tb_flappy_game_ctrl;
   logic       board_clk = 1'b0;
   logic       Reset = 1'b1;
   logic       start_pulse = 0, ack_pulse = 0, jump_pulse = 0, frame_start = 0, pipe_passed = 0;
   logic [9:0] bird_l, bird_r, bird_t, bird_b;
   logic [1:0] pipe_idx;
   logic [9:0] pipe_x_l = 0, pipe_x_r = 0, gap_t = 0, gap_b = 0;
   logic       move_en, jump_req, q_initial, q_play, q_lose;
   logic [7:0] score;
   logic [1:0] hit_pipe;

   logic [9:0] pxl [4], pxr [4], pgt [4], pgb [4];
   int n_checks = 0, n_fail = 0;

   always #5 board_clk = ~board_clk;

   // geometry RAM model: one cycle read latency from pipe_idx
   always @(posedge board_clk) begin
      pipe_x_l <= pxl[pipe_idx];
      pipe_x_r <= pxr[pipe_idx];
      gap_t    <= pgt[pipe_idx];
      gap_b    <= pgb[pipe_idx];
   end

   flappy_game_ctrl #(.TICK_DIV(2), .FLOOR_Y(470), .CEIL_Y(0)) dut (
      .board_clk(board_clk), .Reset(Reset), .start_pulse(start_pulse), .ack_pulse(ack_pulse),
      .jump_pulse(jump_pulse), .frame_start(frame_start), .pipe_passed(pipe_passed),
      .bird_l(bird_l), .bird_r(bird_r), .bird_t(bird_t), .bird_b(bird_b),
      .pipe_idx(pipe_idx), .pipe_x_l(pipe_x_l), .pipe_x_r(pipe_x_r), .gap_t(gap_t), .gap_b(gap_b),
      .move_en(move_en), .jump_req(jump_req), .q_initial(q_initial), .q_play(q_play),
      .q_lose(q_lose), .score(score), .hit_pipe(hit_pipe));

   task automatic clear_pipes();
      for (int k = 0; k < 4; k++) begin
         pxl[k] = 10'd600; pxr[k] = 10'd650; pgt[k] = 10'd150; pgb[k] = 10'd300;
      end
      bird_l = 10'd100; bird_r = 10'd120; bird_t = 10'd200; bird_b = 10'd220;
   endtask

   task automatic pulse_start();
      @(posedge board_clk); #1 start_pulse = 1;
      @(posedge board_clk); #1 start_pulse = 0;
   endtask

   task automatic pulse_ack();
      @(posedge board_clk); #1 ack_pulse = 1;
      @(posedge board_clk); #1 ack_pulse = 0;
   endtask

   task automatic pulse_pp(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge board_clk); #1 pipe_passed = 1;
         @(posedge board_clk); #1 pipe_passed = 0;
      end
   endtask

   // One frame: frame_start sampled at edge 0; reports latency (edges from the
   // frame_start cycle) of the first move_en, move_en count and jump_req with it.
   task automatic run_frame(input int jump_at, input int pp_at, input int fs_at,
                            output int lat, output int n_mv, output logic jr, output logic play_ok);
      lat = -1; n_mv = 0; jr = 0; play_ok = 1;
      @(posedge board_clk); #1 frame_start = 1;
      @(posedge board_clk); #1 frame_start = 0;
      for (int i = 1; i <= 12; i++) begin
         jump_pulse  = (i - 1 == jump_at);
         pipe_passed = (i - 1 == pp_at);
         frame_start = (i - 1 == fs_at);
         @(posedge board_clk); #1;
         if (move_en) begin
            n_mv++;
            if (lat < 0) begin lat = i + 1; jr = jump_req; end
         end
         if (!q_play) play_ok = 0;
      end
      jump_pulse = 0; pipe_passed = 0; frame_start = 0;
   endtask

   task automatic test_reset();
      Reset = 1;
      repeat (2) @(posedge board_clk);
      #1 Reset = 0;
      @(posedge board_clk); #1;
      n_checks++;
      if ({q_initial, q_play, q_lose, move_en, jump_req} !== 5'b10000) begin
         n_fail++; $display("FAIL reset_flags: got %b want 10000", {q_initial, q_play, q_lose, move_en, jump_req});
      end
      n_checks++;
      if ({pipe_idx, score, hit_pipe} !== 12'h000) begin
         n_fail++; $display("FAIL reset_vals: got idx=%0d score=%h hit=%0d want 0/00/0", pipe_idx, score, hit_pipe);
      end
   endtask

   task automatic test_ticks();
      int lat, n; logic jr, ok;
      int exp_lat [4] = '{-1, 10, -1, 10};
      pulse_start();
      n_checks++;
      if (q_play !== 1'b1) begin n_fail++; $display("FAIL start_play: got %b want 1", q_play); end
      for (int f = 0; f < 4; f++) begin
         run_frame(-1, -1, -1, lat, n, jr, ok);
         n_checks++;
         if (lat != exp_lat[f] || n != (exp_lat[f] > 0 ? 1 : 0) || !ok) begin
            n_fail++; $display("FAIL tick_frame%0d: got lat=%0d n=%0d play=%b want lat=%0d", f + 1, lat, n, ok, exp_lat[f]);
         end
      end
   endtask

   task automatic test_jump();
      int lat, n; logic jr, ok;
      run_frame(-1, -1, -1, lat, n, jr, ok);
      @(posedge board_clk); #1 jump_pulse = 1;
      @(posedge board_clk); #1 jump_pulse = 0;
      run_frame(-1, -1, -1, lat, n, jr, ok);
      n_checks++;
      if (lat != 10 || jr !== 1'b1) begin n_fail++; $display("FAIL jump_tick: got lat=%0d jr=%b want 10/1", lat, jr); end
      run_frame(-1, -1, -1, lat, n, jr, ok);
      run_frame(-1, -1, -1, lat, n, jr, ok);
      n_checks++;
      if (lat != 10 || jr !== 1'b0) begin n_fail++; $display("FAIL jump_once: got lat=%0d jr=%b want 10/0", lat, jr); end
      // jump arriving in the UPDATE cycle of a tick frame carries to the next tick
      run_frame(-1, -1, -1, lat, n, jr, ok);
      run_frame(8, -1, -1, lat, n, jr, ok);
      n_checks++;
      if (lat != 10 || jr !== 1'b0) begin n_fail++; $display("FAIL jump_upd_now: got lat=%0d jr=%b want 10/0", lat, jr); end
      run_frame(-1, -1, -1, lat, n, jr, ok);
      run_frame(-1, -1, -1, lat, n, jr, ok);
      n_checks++;
      if (lat != 10 || jr !== 1'b1) begin n_fail++; $display("FAIL jump_upd_carry: got lat=%0d jr=%b want 10/1", lat, jr); end
   endtask

   task automatic test_frame_in_scan();
      int lat, n; logic jr, ok;
      run_frame(-1, -1, -1, lat, n, jr, ok);
      run_frame(-1, -1, 4, lat, n, jr, ok);
      n_checks++;
      if (lat != 10 || n != 1) begin n_fail++; $display("FAIL fs_in_scan: got lat=%0d n=%0d want 10/1", lat, n); end
   endtask

   task automatic test_pipe_hit();
      int lat, n; logic jr, ok;
      pulse_ack();
      pulse_start();
      run_frame(-1, -1, -1, lat, n, jr, ok);
      pxl[2] = 10'd110; pxr[2] = 10'd190; pgt[2] = 10'd150; pgb[2] = 10'd210;
      run_frame(-1, -1, -1, lat, n, jr, ok);
      n_checks++;
      if (q_lose !== 1'b1 || q_play !== 1'b0 || n != 0) begin
         n_fail++; $display("FAIL pipe2_lose: got lose=%b play=%b moves=%0d want 1/0/0", q_lose, q_play, n);
      end
      n_checks++;
      if (hit_pipe !== 2'd2) begin n_fail++; $display("FAIL pipe2_idx: got %0d want 2", hit_pipe); end
      // start is ignored while in LOSE
      pulse_start();
      n_checks++;
      if (q_lose !== 1'b1 || q_initial !== 1'b0) begin n_fail++; $display("FAIL lose_start_ign: got lose=%b init=%b want 1/0", q_lose, q_initial); end
      pulse_ack();
      pulse_start();
      pxl[1] = 10'd110; pxr[1] = 10'd190; pgt[1] = 10'd150; pgb[1] = 10'd210;
      run_frame(-1, -1, -1, lat, n, jr, ok);
      n_checks++;
      if (q_lose !== 1'b1 || hit_pipe !== 2'd1) begin n_fail++; $display("FAIL first_hit: got lose=%b idx=%0d want 1/1", q_lose, hit_pipe); end
      pulse_ack();
      clear_pipes();
   endtask

   task automatic test_gap_and_bounds();
      int lat, n; logic jr, ok;
      pulse_start();
      pxl[0] = 10'd110; pxr[0] = 10'd190; pgt[0] = 10'd150; pgb[0] = 10'd210;
      bird_t = 10'd160; bird_b = 10'd200;
      run_frame(-1, -1, -1, lat, n, jr, ok);
      run_frame(-1, -1, -1, lat, n, jr, ok);
      n_checks++;
      if (!ok || lat != 10) begin n_fail++; $display("FAIL in_gap: got play=%b lat=%0d want 1/10", ok, lat); end
      // top edge touching gap_t is a hit (inclusive)
      bird_t = 10'd150;
      run_frame(-1, -1, -1, lat, n, jr, ok);
      n_checks++;
      if (q_lose !== 1'b1 || hit_pipe !== 2'd0) begin n_fail++; $display("FAIL gap_edge: got lose=%b idx=%0d want 1/0", q_lose, hit_pipe); end
      pulse_ack();
      clear_pipes();
      pulse_start();
      bird_t = 10'd449; bird_b = 10'd469;
      run_frame(-1, -1, -1, lat, n, jr, ok);
      n_checks++;
      if (q_play !== 1'b1) begin n_fail++; $display("FAIL floor_469: got play=%b want 1", q_play); end
      bird_t = 10'd450; bird_b = 10'd470;
      run_frame(-1, -1, -1, lat, n, jr, ok);
      n_checks++;
      if (q_lose !== 1'b1 || hit_pipe !== 2'd0 || n != 0) begin
         n_fail++; $display("FAIL floor_470: got lose=%b idx=%0d moves=%0d want 1/0/0", q_lose, hit_pipe, n);
      end
      pulse_ack();
      clear_pipes();
      pulse_start();
      bird_t = 10'd0; bird_b = 10'd20;
      run_frame(-1, -1, -1, lat, n, jr, ok);
      n_checks++;
      if (q_lose !== 1'b1) begin n_fail++; $display("FAIL ceiling: got lose=%b want 1", q_lose); end
      pulse_ack();
      clear_pipes();
   endtask

   task automatic test_score();
      int lat, n; logic jr, ok;
      pulse_start();
      pulse_pp(9);
      n_checks++;
      if (score !== 8'h09) begin n_fail++; $display("FAIL score_09: got %h want 09", score); end
      pulse_pp(1);
      n_checks++;
      if (score !== 8'h10) begin n_fail++; $display("FAIL score_10: got %h want 10", score); end
      pulse_pp(89);
      n_checks++;
      if (score !== 8'h99) begin n_fail++; $display("FAIL score_99: got %h want 99", score); end
      pulse_pp(6);
      n_checks++;
      if (score !== 8'h99) begin n_fail++; $display("FAIL score_sat: got %h want 99", score); end
      bird_t = 10'd450; bird_b = 10'd470;
      run_frame(-1, -1, -1, lat, n, jr, ok);
      pulse_ack();
      n_checks++;
      if (q_initial !== 1'b1 || score !== 8'h99) begin n_fail++; $display("FAIL ack_hold: got init=%b score=%h want 1/99", q_initial, score); end
      pulse_start();
      n_checks++;
      if (score !== 8'h00) begin n_fail++; $display("FAIL start_clear: got %h want 00", score); end
      // pipe_passed in the UPDATE cycle that goes to LOSE still counts
      run_frame(-1, 8, -1, lat, n, jr, ok);
      n_checks++;
      if (q_lose !== 1'b1 || score !== 8'h01) begin n_fail++; $display("FAIL pp_on_lose: got lose=%b score=%h want 1/01", q_lose, score); end
      pulse_pp(2);
      n_checks++;
      if (score !== 8'h01) begin n_fail++; $display("FAIL pp_in_lose: got %h want 01", score); end
      pulse_ack();
      clear_pipes();
   endtask

   task automatic test_reset_mid_scan();
      pulse_start();
      pulse_pp(3);
      @(posedge board_clk); #1 frame_start = 1;
      @(posedge board_clk); #1 frame_start = 0;
      repeat (3) @(posedge board_clk);
      #1;
      n_checks++;
      if (pipe_idx !== 2'd1) begin n_fail++; $display("FAIL scan_idx: got %0d want 1", pipe_idx); end
      Reset = 1;
      #1;
      n_checks++;
      if ({q_initial, q_play, q_lose, move_en, jump_req, pipe_idx, score, hit_pipe} !== {5'b10000, 12'h000}) begin
         n_fail++; $display("FAIL mid_scan_reset: got init=%b play=%b idx=%0d score=%h want 1/0/0/00", q_initial, q_play, pipe_idx, score);
      end
      @(posedge board_clk); #1 Reset = 0;
   endtask

   initial begin
      clear_pipes();
      test_reset();
      test_ticks();
      test_jump();
      test_frame_in_scan();
      test_pipe_hit();
      test_gap_and_bounds();
      test_score();
      test_reset_mid_scan();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/flappy_game_ctrl.md
Name: flappy_game_ctrl

Overview:
Top-level game sequencer for the Flappy VGA design. It owns the Initial/Play/Lose state machine and turns one-per-frame VGA pulses into move-enable ticks for the pipe X RAM and flight physics. Once per frame it time-multiplexes the pipe geometry read port across the four pipes to detect collisions, and it keeps the BCD score driven to the SSDs. It replaces the scattered start/ack/lose wiring around the VGA top level with a single controller.

Parameters:
TICK_DIV, 2, frames per movement tick (1..15)
FLOOR_Y, 470, bird bottom edge at or below this row is a floor collision
CEIL_Y, 0, bird top edge at or above this row is a ceiling collision

Ports:
board_clk  in  1  system clock
Reset  in  1  asynchronous, active-high; clock board_clk
start_pulse  in  1  debounced single-cycle Start (BtnU)
ack_pulse  in  1  debounced single-cycle Ack (BtnD)
jump_pulse  in  1  debounced single-cycle Jump (BtnC)
frame_start  in  1  single-cycle pulse at start of vertical blanking
pipe_passed  in  1  single-cycle pulse from X RAM when a pipe leaves scope
bird_l, bird_r, bird_t, bird_b  in  10 each  bird bounding box
pipe_idx  out  2  pipe select for geometry read
pipe_x_l, pipe_x_r  in  10 each  selected pipe left/right X; valid 1 cycle after pipe_idx
gap_t, gap_b  in  10 each  selected pipe gap top/bottom Y (gap_t < gap_b); same timing
move_en  out  1  single-cycle movement tick to X RAM and physics
jump_req  out  1  qualifies move_en; bird jumps on this tick
q_initial, q_play, q_lose  out  1 each  one-hot state
score  out  8  two BCD digits, [7:4] tens, [3:0] units
hit_pipe  out  2  index of the colliding pipe, held in LOSE

Behaviour:
- Reset: state INITIAL; q_initial=1, others 0; move_en=0, jump_req=0, pipe_idx=0, score=0x00, hit_pipe=0; frame counter, jump_pending and hit flag cleared. Reset mid-scan aborts immediately.
- States: INITIAL, WAIT, SCAN, UPDATE, LOSE. q_play=1 in WAIT/SCAN/UPDATE.
- INITIAL: start_pulse -> WAIT; clears score, frame counter, jump_pending. Other pulses are ignored.
- WAIT: frame_start -> SCAN next cycle, with pipe_idx=0.
- SCAN: 8 cycles, two per pipe.
  - Cycle 2k drives pipe_idx=k. Cycle 2k+1 samples the geometry.
  - Pipe k hits when bird_r >= pipe_x_l AND bird_l <= pipe_x_r AND (bird_t <= gap_t OR bird_b >= gap_b). Inclusive compares, unsigned 10-bit.
  - The first hit latches hit_pipe=k. Later hits do not overwrite it.
  - After cycle 7 -> UPDATE. frame_start during SCAN/UPDATE is ignored.
- UPDATE (1 cycle):
  - Also hit if bird_b >= FLOOR_Y or bird_t <= CEIL_Y; hit_pipe unchanged for these.
  - If hit -> LOSE; no move_en.
  - Else if frame counter == TICK_DIV-1: move_en=1, jump_req=jump_pending, clear jump_pending, counter=0. Otherwise counter+1.
  - Next state WAIT.
  - Latency: frame_start to move_en = 10 cycles.
- jump_pulse in any play state sets jump_pending. A set in the same cycle as the UPDATE clear wins, so the jump carries to the next tick. Cleared on entering LOSE or INITIAL.
- score: on pipe_passed while q_play, BCD increment. Units 9 -> 0 with tens +1. Saturates at 0x99. pipe_passed in the same cycle as the transition to LOSE still counts.
- LOSE: outputs frozen, score and hit_pipe held. ack_pulse -> INITIAL; score is retained until the next start_pulse. start_pulse is ignored.
- One-hot outputs are registered and never all-zero after reset.

Test Plan:
- Reset, start_pulse, TICK_DIV=2, four frame_starts with no overlap -> move_en pulses after frames 2 and 4, each exactly 10 cycles after its frame_start; q_play=1 throughout.
- jump_pulse between frames 1 and 2 -> jump_req=1 coincident with the frame-2 move_en only; jump_pulse in the same cycle as UPDATE -> jump_req on the following tick.
- Bird (100,120,200,220), pipe 2 = x 110..190, gap 150..210 -> LOSE after UPDATE, hit_pipe=2, no move_en; pipes 1 and 2 both overlapping -> hit_pipe=1.
- Bird inside gap (t=160, b=200, gap 150..210), overlapping in X -> no hit; bird_b=470 with no pipe overlap -> LOSE, hit_pipe=0.
- 105 pipe_passed pulses -> score sequences 0x09->0x10 and saturates at 0x99; ack in LOSE -> INITIAL with score held; start_pulse -> score 0x00.
- Reset asserted mid-SCAN -> all outputs at reset values within the same cycle; a start_pulse in LOSE and a frame_start in SCAN are both ignored.
